// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of both masters' request fields and the downstream MMIO bus.
interface mmio_arb_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) ();
    logic [1:0]        req;
    logic [1:0]        wr;
    logic [1:0]        lock;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              mmio_cs;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;

    // Arbiter view: consumes requests and the controller's read return.
    modport slave (
        input  req, wr, lock, addr0, addr1, wdata0, wdata1, mmio_rd_data,
        output ack, rdata, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

    modport master (
        output req, wr, lock, addr0, addr1, wdata0, wdata1, mmio_rd_data,
        input  ack, rdata, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );
endinterface

// File: rtl/mmio_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin winner select.
module rr_arb2
    import mmio_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_win
);
    assign o_valid = |i_req;
    // On a tie the master that did not win last time goes first.
    assign o_win   = (i_req == 2'b11) ? ~i_last : i_req[M1];
endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO arbiter: one access at a time, round-robin fairness,
// bounded lock for back-to-back accesses, all outputs registered.
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W   = 21,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic       clk,
    input  logic       reset,
    mmio_arb_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t        r_state, w_state_next;
    logic              r_last, w_last_next;
    logic              r_win, w_win_next;
    logic              r_locked, w_locked_next;
    logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_next;
    logic              r_cs, w_cs_next;
    logic              r_wr, w_wr_next;
    logic              r_rd, w_rd_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next;
    logic [1:0]        r_ack, w_ack_next;
    logic [DATA_W-1:0] r_rdata, w_rdata_next;

    logic              w_arb_valid;
    logic              w_arb_win;
    logic              w_gnt_idx;
    logic              w_gnt_wr;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic [1:0]        w_ack_sel;

    rr_arb2 u_rr_arb2 (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_valid (w_arb_valid),
        .o_win   (w_arb_win)
    );

    // A locked continuation bypasses arbitration and keeps the current winner.
    assign w_gnt_idx   = (r_state == DONE) ? r_win : w_arb_win;
    assign w_gnt_wr    = bus.wr[w_gnt_idx];
    assign w_gnt_addr  = (w_gnt_idx == M0) ? bus.addr0  : bus.addr1;
    assign w_gnt_wdata = (w_gnt_idx == M0) ? bus.wdata0 : bus.wdata1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign w_ack_sel[gi] = (r_win == 1'(gi));
    end

    always_comb begin
        w_state_next    = r_state;
        w_last_next     = r_last;
        w_win_next      = r_win;
        w_locked_next   = r_locked;
        w_lock_cnt_next = r_lock_cnt;
        w_cs_next       = 1'b0;
        w_wr_next       = 1'b0;
        w_rd_next       = 1'b0;
        w_addr_next     = '0;
        w_wdata_next    = '0;
        w_ack_next      = 2'b00;
        w_rdata_next    = r_rdata;

        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_next    = ACCESS;
                    w_win_next      = w_gnt_idx;
                    w_last_next     = w_gnt_idx;
                    w_locked_next   = bus.lock[w_gnt_idx];
                    w_lock_cnt_next = CNT_W'(1);
                    w_cs_next       = 1'b1;
                    w_wr_next       = w_gnt_wr;
                    w_rd_next       = ~w_gnt_wr;
                    w_addr_next     = w_gnt_addr;
                    w_wdata_next    = w_gnt_wdata;
                end
            end
            ACCESS: begin
                w_state_next = DONE;
                w_ack_next   = w_ack_sel;
                if (r_rd) begin
                    w_rdata_next = bus.mmio_rd_data;
                end
            end
            DONE: begin
                if (r_locked && bus.req[r_win] && (r_lock_cnt < CNT_W'(MAX_LOCK))) begin
                    w_state_next    = ACCESS;
                    w_last_next     = r_win;
                    w_locked_next   = bus.lock[r_win];
                    w_lock_cnt_next = r_lock_cnt + CNT_W'(1);
                    w_cs_next       = 1'b1;
                    w_wr_next       = w_gnt_wr;
                    w_rd_next       = ~w_gnt_wr;
                    w_addr_next     = w_gnt_addr;
                    w_wdata_next    = w_gnt_wdata;
                end else begin
                    w_state_next    = IDLE;
                    w_lock_cnt_next = '0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_cs       <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ack      <= 2'b00;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_last     <= w_last_next;
            r_win      <= w_win_next;
            r_locked   <= w_locked_next;
            r_lock_cnt <= w_lock_cnt_next;
            r_cs       <= w_cs_next;
            r_wr       <= w_wr_next;
            r_rd       <= w_rd_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_ack      <= w_ack_next;
            r_rdata    <= w_rdata_next;
        end
    end

    assign bus.mmio_cs      = r_cs;
    assign bus.mmio_wr      = r_wr;
    assign bus.mmio_rd      = r_rd;
    assign bus.mmio_addr    = r_addr;
    assign bus.mmio_wr_data = r_wdata;
    assign bus.ack          = r_ack;
    assign bus.rdata        = r_rdata;

endmodule
